// File: rtl/alu_mc.sv
// Handshaked RV32I register-register ALU with an iterative shift-add MUL.
// Results and the zero flag are registered and presented on a valid/ready port.
module alu_mc #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [9:0]       selector,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             busy
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] out_q;
  logic             zero_q;

  logic [WIDTH-1:0] alu_d;
  logic [WIDTH-1:0] acc_d;
  logic [SHW-1:0]   shamt;
  logic             is_mul;
  logic             accept;

  assign shamt  = in1[SHW-1:0];
  assign is_mul = MUL_EN && (selector == 10'b0000001_000);
  assign acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    alu_d = in0;
    case (selector)
      10'b0000000_000: alu_d = in0 + in1;
      10'b0100000_000: alu_d = in0 - in1;
      10'b0000000_001: alu_d = in0 << shamt;
      10'b0000000_010: alu_d = {{(WIDTH-1){1'b0}}, ($signed(in0) < $signed(in1))};
      10'b0000000_011: alu_d = {{(WIDTH-1){1'b0}}, (in0 < in1)};
      10'b0000000_100: alu_d = in0 ^ in1;
      10'b0000000_101: alu_d = in0 >> shamt;
      10'b0100000_101: alu_d = WIDTH'($signed(in0) >>> shamt);
      10'b0000000_110: alu_d = in0 | in1;
      10'b0000000_111: alu_d = in0 & in1;
      default:         alu_d = in0;
    endcase
  end

  // A completed result may be consumed and replaced by a new op on the same edge.
  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_MUL);
  assign out       = out_q;
  assign zero      = zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            if (is_mul) begin
              acc_q    <= '0;
              mcand_q  <= in0;
              mplier_q <= in1;
              cnt_q    <= '0;
              state_q  <= S_MUL;
            end else begin
              out_q   <= alu_d;
              zero_q  <= (alu_d == '0);
              state_q <= S_DONE;
            end
          end else if ((state_q == S_DONE) && out_ready) begin
            state_q <= S_IDLE;
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            out_q   <= acc_d;
            zero_q  <= (acc_d == '0);
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
